bayer_window_seq: RTL

- Streaming controller that sequences the 2x2 Bayer demosaic mux.
- Accepts white-balanced pixels in raster order, one per handshake, and buffers the previous image row.
- For every pixel with row>0 and col>0, emits the 2x2 window ending at that pixel on the mux inputs wb_1..wb_4, together with the matching row/col parity selects.
- Sits between the white-balance stage and the RGGB channel mux.

---
 rtl/bayer_window_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bayer_window_seq.sv
// rtl/bayer_window_seq.sv - sequences 2x2 Bayer windows from a raster pixel stream
module bayer_window_seq #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter bit ROW_OFS = 1'b0,
  parameter bit COL_OFS = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  output logic [7:0] wb_1,
  output logic [7:0] wb_2,
  output logic [7:0] wb_3,
  output logic [7:0] wb_4,
  output logic       row,
  output logic       col,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, ROW0, STREAM, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] c;
  logic [RW-1:0] r;

  // line_buf[k] holds the most recent sample seen at column k (previous row
  // ahead of c, current row behind it); left_pix is P(r,c-1) and top_left
  // is P(r-1,c-1), captured before its line_buf slot was overwritten.
  logic [7:0] line_buf [WIDTH];
  logic [7:0] left_pix;
  logic [7:0] top_left;

  logic accept;
  logic last_col;
  logic last_row;
  logic load;

  assign in_ready = (state == ROW0) || (state == STREAM && (!out_valid || out_ready));
  assign accept   = in_valid && in_ready;
  assign last_col = (c == CW'(WIDTH - 1));
  assign last_row = (r == RW'(HEIGHT - 1));
  assign load     = (state == STREAM) && accept && (c != '0);
  assign busy     = (state != IDLE);

  // Line buffer and neighbour capture, updated only on an accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[c] <= in_pixel;
      left_pix    <= in_pixel;
      top_left    <= line_buf[c];
    end
  end

  // Frame FSM, raster counters and registered window outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      c          <= '0;
      r          <= '0;
      wb_1       <= '0;
      wb_2       <= '0;
      wb_3       <= '0;
      wb_4       <= '0;
      row        <= 1'b0;
      col        <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (load) begin
        wb_1      <= top_left;
        wb_2      <= line_buf[c];
        wb_3      <= left_pix;
        wb_4      <= in_pixel;
        row       <= ~r[0] ^ ROW_OFS;
        col       <= ~c[0] ^ COL_OFS;
        out_valid <= 1'b1;
      end

      if (accept) begin
        if (last_col) begin
          c <= '0;
          r <= last_row ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // a start coinciding with the end-of-frame pulse is dropped
          if (start && !frame_done) begin
            state <= ROW0;
            c     <= '0;
            r     <= '0;
          end
        end
        ROW0: begin
          if (accept && last_col) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept && last_col && last_row) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_valid && out_ready) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
